// File: rtl/rgmii_pkg.sv
// Shared types and constants for the PHY-side RGMII RX source: speed codes,
// RX clock half-periods, preamble/SFD bytes, FSM states and the per-byte symbol.
package rgmii_pkg;

  typedef enum logic [1:0] {
    SPEED_10   = 2'b00,
    SPEED_100  = 2'b01,
    SPEED_1000 = 2'b10
  } speed_e;

  localparam int HP_1000 = 1;
  localparam int HP_100  = 5;
  localparam int HP_10   = 50;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_DATA,
    ST_DROP,
    ST_IFG
  } state_e;

  // One byte slot on the wire; inband marks idle bytes that carry link status.
  typedef struct packed {
    logic [7:0] data;
    logic       dv;
    logic       er;
    logic       inband;
  } sym_t;

  localparam sym_t SYM_IDLE  = '{data: 8'h00,         dv: 1'b0, er: 1'b0, inband: 1'b1};
  localparam sym_t SYM_DROP  = '{data: 8'h00,         dv: 1'b0, er: 1'b0, inband: 1'b0};
  localparam sym_t SYM_ABORT = '{data: 8'h00,         dv: 1'b1, er: 1'b1, inband: 1'b0};
  localparam sym_t SYM_PRE   = '{data: PREAMBLE_BYTE, dv: 1'b1, er: 1'b0, inband: 1'b0};
  localparam sym_t SYM_SFD   = '{data: SFD_BYTE,      dv: 1'b1, er: 1'b0, inband: 1'b0};

  // Code 2'b11 is treated as gigabit.
  function automatic logic is_gig(input logic [1:0] speed);
    return speed[1];
  endfunction

  function automatic logic [5:0] half_period(input logic [1:0] speed);
    case (speed)
      SPEED_10:  return 6'(HP_10);
      SPEED_100: return 6'(HP_100);
      default:   return 6'(HP_1000);
    endcase
  endfunction

endpackage

// File: rtl/rgmii_phy_clkgen.sv
// RGMII RX clock generator: half-period timer, rgmii_rx_clk, and rise/fall/byte-slot
// strobes that are high in the cycle whose clock edge produces the toggle.
module rgmii_phy_clkgen
  import rgmii_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] speed,
  output logic       rx_clk,
  output logic       rise,
  output logic       fall,
  output logic       slot
);

  logic [5:0] timer_q;
  logic       odd_q;
  logic       toggle;
  logic       gig;

  assign gig = is_gig(speed);
  // >= rather than == so a speed change never strands the timer above the new limit.
  assign toggle = timer_q >= (half_period(speed) - 6'd1);
  assign rise   = toggle & ~rx_clk;
  assign fall   = toggle & rx_clk;
  assign slot   = rise & (gig | ~odd_q);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_q <= 6'd0;
      rx_clk  <= 1'b0;
      odd_q   <= 1'b0;
    end else begin
      if (toggle) begin
        timer_q <= 6'd0;
        rx_clk  <= ~rx_clk;
      end else begin
        timer_q <= timer_q + 6'd1;
      end
      if (rise) odd_q <= gig ? 1'b0 : ~odd_q;
    end
  end

endmodule

// File: rtl/rgmii_phy_rx_driver.sv
// PHY-side RGMII source: frames AXI-stream bytes with preamble/SFD, DV/ER and IFG.
// Optional feature: RGMII_PHY_INBAND_STATUS_EN drives link status on rxd while idle.
module rgmii_phy_rx_driver
  import rgmii_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_IFG      = 12
) (
  input  logic       clk250,
  input  logic       clk250_rst_n,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  input  logic [1:0] speed,
  input  logic [7:0] ifg_delay,
  input  logic       link_up,
  input  logic       full_duplex,
  output logic       rgmii_rx_clk,
  output logic [3:0] rgmii_rxd,
  output logic       rgmii_rx_ctl,
  output logic       busy,
  output logic       underflow
);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] speed_q;
  sym_t       cur_q, nxt;
  logic       rise, fall, slot, gig;
  logic [3:0] status;
  logic [7:0] gap;

  rgmii_phy_clkgen u_clkgen (
    .clk    (clk250),
    .rst_n  (clk250_rst_n),
    .speed  (speed_q),
    .rx_clk (rgmii_rx_clk),
    .rise   (rise),
    .fall   (fall),
    .slot   (slot)
  );

  assign gig  = is_gig(speed_q);
  assign gap  = (ifg_delay > 8'(MIN_IFG)) ? ifg_delay : 8'(MIN_IFG);
  assign busy = (state_q != ST_IDLE);

`ifdef RGMII_PHY_INBAND_STATUS_EN
  assign status = {full_duplex, speed_q, link_up};
`else
  logic unused_inband;
  assign unused_inband = link_up ^ full_duplex;
  assign status        = 4'h0;
`endif

  always_ff @(posedge clk250) begin
    if (!clk250_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      speed_q <= SPEED_1000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == ST_IDLE) speed_q <= speed;
    end
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    nxt           = SYM_IDLE;
    s_axis_tready = 1'b0;
    underflow     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (slot && s_axis_tvalid) begin
          nxt     = SYM_PRE;
          cnt_d   = 8'd1;
          state_d = (PREAMBLE_LEN > 1) ? ST_PREAMBLE : ST_SFD;
        end
      end
      ST_PREAMBLE: begin
        if (slot) begin
          nxt   = SYM_PRE;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'(PREAMBLE_LEN - 1)) state_d = ST_SFD;
        end
      end
      ST_SFD: begin
        if (slot) begin
          nxt     = SYM_SFD;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (slot) begin
          if (s_axis_tvalid) begin
            s_axis_tready = 1'b1;
            nxt = '{data: s_axis_tdata, dv: 1'b1, er: s_axis_tlast & s_axis_tuser, inband: 1'b0};
            if (s_axis_tlast) begin
              state_d = ST_IFG;
              cnt_d   = gap;
            end
          end else begin
            underflow = 1'b1;
            nxt       = SYM_ABORT;
            state_d   = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        s_axis_tready = 1'b1;
        nxt           = SYM_DROP;
        if (s_axis_tvalid && s_axis_tlast) begin
          state_d = ST_IFG;
          cnt_d   = gap;
        end
      end
      ST_IFG: begin
        if (slot) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Wire outputs change on the same edge as rgmii_rx_clk, so a byte's symbol is
  // captured at its slot and replayed for the remaining phases.
  always_ff @(posedge clk250) begin
    if (!clk250_rst_n) begin
      rgmii_rxd    <= 4'h0;
      rgmii_rx_ctl <= 1'b0;
      cur_q        <= SYM_IDLE;
    end else begin
      if (slot) cur_q <= nxt;
      if (rise) begin
        rgmii_rx_ctl <= slot ? nxt.dv : cur_q.dv;
        if (slot) rgmii_rxd <= nxt.inband ? status : nxt.data[3:0];
        else      rgmii_rxd <= cur_q.inband ? status : cur_q.data[7:4];
      end else if (fall) begin
        rgmii_rx_ctl <= cur_q.dv ^ cur_q.er;
        if (cur_q.inband) rgmii_rxd <= status;
        else if (gig)     rgmii_rxd <= cur_q.data[7:4];
      end
    end
  end

endmodule
